multicycle_sequencer: RTL and testbench

- Parametrised next-generation control sequencer for the multicycle MIPS core. Takes a compact instruction-class code from the decoder instead of a one-hot instruction bus.
- Adds three things the current control FSM lacks: variable-latency memory handshakes, a multiply/divide wait state, and timeout-driven bus and MD exceptions.
- Also provides a retired-instruction counter.
- Sits between the decoder and the datapath enables (PC, IR, Y, regfile, HI/LO, CP0).

---
 rtl/cpu_ctrl_pkg.sv | 40 ++++
 rtl/seq_wait_timer.sv | 37 +++
 rtl/multicycle_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: states, instruction
// classes and exception causes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_PAUSE   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_JUDGE   = 4'd3,
    ST_EXEC    = 4'd4,
    ST_MEM     = 4'd5,
    ST_MD_WAIT = 4'd6,
    ST_WB      = 4'd7,
    ST_EXC     = 4'd8
  } state_t;

  localparam logic [3:0] IC_NOP       = 4'd0;
  localparam logic [3:0] IC_ALU_R     = 4'd1;
  localparam logic [3:0] IC_ALU_I     = 4'd2;
  localparam logic [3:0] IC_LOAD      = 4'd3;
  localparam logic [3:0] IC_STORE     = 4'd4;
  localparam logic [3:0] IC_BRANCH    = 4'd5;
  localparam logic [3:0] IC_JUMP      = 4'd6;
  localparam logic [3:0] IC_JUMP_LINK = 4'd7;
  localparam logic [3:0] IC_MULDIV    = 4'd8;
  localparam logic [3:0] IC_TRAP_COND = 4'd9;
  localparam logic [3:0] IC_TRAP      = 4'd10;
  localparam logic [3:0] IC_ERET      = 4'd11;
  localparam logic [3:0] IC_MFC0      = 4'd12;
  localparam logic [3:0] IC_MTC0      = 4'd13;
  localparam logic [3:0] IC_MOVE_HILO = 4'd14;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_TRAP = 3'd1;
  localparam logic [2:0] CAUSE_IMEM = 3'd2;
  localparam logic [2:0] CAUSE_DMEM = 3'd3;
  localparam logic [2:0] CAUSE_MD   = 3'd4;
  localparam logic [2:0] CAUSE_IRQ  = 3'd5;

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating wait counter with synchronous clear; expired flags the cycle whose
// increment brings the count up to the programmed limit.
module seq_wait_timer #(
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [WAIT_W-1:0] limit,
  output logic              expired
);

  logic [WAIT_W-1:0] count_q, count_d;
  logic [WAIT_W:0]   count_inc;

  always_comb begin
    count_inc = {1'b0, count_q} + {{WAIT_W{1'b0}}, 1'b1};
    if (clear) begin
      count_d = '0;
    end else if (&count_q) begin
      count_d = count_q;
    end else begin
      count_d = count_inc[WAIT_W-1:0];
    end
  end

  assign expired = (count_inc >= {1'b0, limit});

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control sequencer; MULTICYCLE_SEQUENCER_IRQ_EN enables irq redirect.
// state | meaning: PAUSE reset hold, FETCH imem, DECODE pc+4, JUDGE cond, EXEC op, MEM dmem, MD_WAIT mul/div, WB regfile, EXC exception
module multicycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int MD_TIMEOUT  = 63,
  parameter int WAIT_W      = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       inst_class,
  input  logic             cond_true,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             md_done,
  input  logic             irq,
  output logic [3:0]       state,
  output logic             imem_req,
  output logic             ir_wena,
  output logic             pc_wena,
  output logic             y_ena,
  output logic             rf_wena,
  output logic             dmem_req,
  output logic             dmem_wena,
  output logic             md_start,
  output logic             hilo_wena,
  output logic             cp0_wena,
  output logic             eret,
  output logic             exc_take,
  output logic [2:0]       exc_cause,
  output logic [CNT_W-1:0] retired
);

  state_t             state_q, state_d;
  logic [2:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic [WAIT_W-1:0]  timer_limit;
  logic               timer_expired;

  seq_wait_timer #(.WAIT_W(WAIT_W)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    retire      = 1'b0;
    timer_limit = WAIT_W'(MEM_TIMEOUT);
    imem_req    = 1'b0;
    ir_wena     = 1'b0;
    pc_wena     = 1'b0;
    y_ena       = 1'b0;
    rf_wena     = 1'b0;
    dmem_req    = 1'b0;
    dmem_wena   = 1'b0;
    md_start    = 1'b0;
    hilo_wena   = 1'b0;
    cp0_wena    = 1'b0;
    eret        = 1'b0;
    exc_take    = 1'b0;
    exc_cause   = CAUSE_NONE;

    case (state_q)
      ST_PAUSE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        y_ena    = 1'b1;
        if (imem_ready) begin
          ir_wena = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_EXC;
          cause_d = CAUSE_IMEM;
        end
      end
      ST_DECODE: begin
        pc_wena = 1'b1;
        state_d = (inst_class == IC_BRANCH || inst_class == IC_TRAP_COND) ? ST_JUDGE : ST_EXEC;
      end
      ST_JUDGE: begin
        y_ena = 1'b1;
        if (!cond_true) begin
          retire = 1'b1;
        end else if (inst_class == IC_TRAP_COND) begin
          state_d = ST_EXC;
          cause_d = CAUSE_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (inst_class)
          IC_ALU_R, IC_ALU_I: begin
            y_ena   = 1'b1;
            state_d = ST_WB;
          end
          IC_LOAD, IC_STORE: begin
            y_ena   = 1'b1;
            state_d = ST_MEM;
          end
          IC_MULDIV: begin
            md_start = 1'b1;
            state_d  = ST_MD_WAIT;
          end
          IC_BRANCH, IC_JUMP: begin
            pc_wena = 1'b1;
            retire  = 1'b1;
          end
          IC_ERET: begin
            pc_wena = 1'b1;
            eret    = 1'b1;
            retire  = 1'b1;
          end
          IC_JUMP_LINK: begin
            pc_wena = 1'b1;
            rf_wena = 1'b1;
            retire  = 1'b1;
          end
          IC_MFC0: begin
            rf_wena = 1'b1;
            retire  = 1'b1;
          end
          IC_MTC0: begin
            cp0_wena = 1'b1;
            retire   = 1'b1;
          end
          IC_MOVE_HILO: begin
            hilo_wena = 1'b1;
            retire    = 1'b1;
          end
          IC_TRAP: begin
            state_d = ST_EXC;
            cause_d = CAUSE_TRAP;
          end
          default: retire = 1'b1;
        endcase
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        dmem_wena = (inst_class == IC_STORE);
        if (dmem_ready) begin
          if (inst_class == IC_STORE) begin
            retire = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (timer_expired) begin
          state_d = ST_EXC;
          cause_d = CAUSE_DMEM;
        end
      end
      ST_MD_WAIT: begin
        timer_limit = WAIT_W'(MD_TIMEOUT);
        if (md_done) begin
          hilo_wena = 1'b1;
          retire    = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_EXC;
          cause_d = CAUSE_MD;
        end
      end
      ST_WB: begin
        rf_wena = 1'b1;
        retire  = 1'b1;
      end
      ST_EXC: begin
        exc_take  = 1'b1;
        pc_wena   = 1'b1;
        exc_cause = cause_q;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_PAUSE;
    endcase

    // Every retiring path lands in FETCH unless an interrupt redirects it.
    if (retire) begin
      state_d = ST_FETCH;
`ifdef MULTICYCLE_SEQUENCER_IRQ_EN
      if (irq) begin
        state_d = ST_EXC;
        cause_d = CAUSE_IRQ;
      end
`endif
    end

    retired_d = retired_q + CNT_W'(retire);
  end

`ifndef MULTICYCLE_SEQUENCER_IRQ_EN
  logic irq_unused;
  assign irq_unused = irq;
`endif

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PAUSE;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction expected state/strobe paths
// built from the sequencing rules, driven with random handshake timing.
module tb_multicycle_sequencer;

  localparam int MEM_T = 15;
  localparam int MD_T  = 63;

  localparam logic [3:0] S_PAUSE = 0, S_FETCH = 1, S_DECODE = 2, S_JUDGE = 3, S_EXEC = 4,
                         S_MEM = 5, S_MDW = 6, S_WB = 7, S_EXC = 8;
  localparam logic [3:0] C_NOP = 0, C_ALUR = 1, C_ALUI = 2, C_LOAD = 3, C_STORE = 4,
                         C_BR = 5, C_J = 6, C_JAL = 7, C_MD = 8, C_TRAPC = 9, C_TRAP = 10,
                         C_ERET = 11, C_MFC0 = 12, C_MTC0 = 13, C_HILO = 14, C_RSVD = 15;
  localparam logic [11:0] B_IMEM = 12'h800, B_IR = 12'h400, B_PC = 12'h200, B_Y = 12'h100,
                          B_RF = 12'h080, B_DREQ = 12'h040, B_DWE = 12'h020, B_MDS = 12'h010,
                          B_HILO = 12'h008, B_CP0 = 12'h004, B_ERET = 12'h002, B_EXC = 12'h001;
`ifdef MULTICYCLE_SEQUENCER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  inst_class = '0;
  logic        cond_true = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, md_done = 1'b0, irq = 1'b0;
  logic [3:0]  state;
  logic        imem_req, ir_wena, pc_wena, y_ena, rf_wena, dmem_req, dmem_wena;
  logic        md_start, hilo_wena, cp0_wena, eret, exc_take;
  logic [2:0]  exc_cause;
  logic [31:0] retired;
  logic [11:0] strobes;

  multicycle_sequencer dut (
    .clk(clk), .reset_n(reset_n), .inst_class(inst_class), .cond_true(cond_true),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .md_done(md_done), .irq(irq),
    .state(state), .imem_req(imem_req), .ir_wena(ir_wena), .pc_wena(pc_wena), .y_ena(y_ena),
    .rf_wena(rf_wena), .dmem_req(dmem_req), .dmem_wena(dmem_wena), .md_start(md_start),
    .hilo_wena(hilo_wena), .cp0_wena(cp0_wena), .eret(eret), .exc_take(exc_take),
    .exc_cause(exc_cause), .retired(retired)
  );

  assign strobes = {imem_req, ir_wena, pc_wena, y_ena, rf_wena, dmem_req, dmem_wena,
                    md_start, hilo_wena, cp0_wena, eret, exc_take};

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [3:0]  st;
    logic        im, dm, md, cnd, irq;
    logic [11:0] stb;
    logic [2:0]  cause;
    int          ret;
  } step_t;

  step_t q[$];
  int    exp_ret = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int v);
    return (v < 0) ? 1'($urandom_range(0, 1)) : 1'(v);
  endfunction

  function automatic void push(input logic [3:0] cls, input logic [3:0] st, input logic [11:0] stb,
                               input logic [2:0] cause, input logic irq_v,
                               input int im = -1, input int dm = -1, input int md = -1,
                               input int cnd = -1);
    step_t s;
    s.cls = cls; s.st = st; s.stb = stb; s.cause = cause; s.irq = irq_v; s.ret = exp_ret;
    s.im = pick(im); s.dm = pick(dm); s.md = pick(md); s.cnd = pick(cnd);
    q.push_back(s);
  endfunction

  function automatic void retire_at(input logic [3:0] cls, input logic irq_v);
    exp_ret++;
    if (IRQ_EN && irq_v) push(cls, S_EXC, B_EXC | B_PC, 3'd5, irq_v);
  endfunction

  // Expected path of one instruction: fd/dd/mdd are wait cycles before the ready/done pulse.
  function automatic void build(input logic [3:0] cls, input logic cnd, input int fd,
                                input int dd, input int mdd, input logic irq_v);
    logic [11:0] mstb;
    if (fd >= MEM_T) begin
      for (int i = 0; i < MEM_T; i++) push(cls, S_FETCH, B_IMEM | B_Y, 0, irq_v, 0);
      push(cls, S_EXC, B_EXC | B_PC, 3'd2, irq_v);
      return;
    end
    for (int i = 0; i < fd; i++) push(cls, S_FETCH, B_IMEM | B_Y, 0, irq_v, 0);
    push(cls, S_FETCH, B_IMEM | B_Y | B_IR, 0, irq_v, 1);
    push(cls, S_DECODE, B_PC, 0, irq_v);
    if (cls == C_BR || cls == C_TRAPC) begin
      push(cls, S_JUDGE, B_Y, 0, irq_v, -1, -1, -1, int'(cnd));
      if (!cnd) begin retire_at(cls, irq_v); return; end
      if (cls == C_TRAPC) begin push(cls, S_EXC, B_EXC | B_PC, 3'd1, irq_v); return; end
    end
    case (cls)
      C_ALUR, C_ALUI: begin
        push(cls, S_EXEC, B_Y, 0, irq_v);
        push(cls, S_WB, B_RF, 0, irq_v);
        retire_at(cls, irq_v);
      end
      C_LOAD, C_STORE: begin
        push(cls, S_EXEC, B_Y, 0, irq_v);
        mstb = B_DREQ | ((cls == C_STORE) ? B_DWE : 12'h0);
        if (dd >= MEM_T) begin
          for (int i = 0; i < MEM_T; i++) push(cls, S_MEM, mstb, 0, irq_v, -1, 0);
          push(cls, S_EXC, B_EXC | B_PC, 3'd3, irq_v);
        end else begin
          for (int i = 0; i < dd; i++) push(cls, S_MEM, mstb, 0, irq_v, -1, 0);
          push(cls, S_MEM, mstb, 0, irq_v, -1, 1);
          if (cls == C_LOAD) push(cls, S_WB, B_RF, 0, irq_v);
          retire_at(cls, irq_v);
        end
      end
      C_MD: begin
        push(cls, S_EXEC, B_MDS, 0, irq_v);
        if (mdd >= MD_T) begin
          for (int i = 0; i < MD_T; i++) push(cls, S_MDW, 0, 0, irq_v, -1, -1, 0);
          push(cls, S_EXC, B_EXC | B_PC, 3'd4, irq_v);
        end else begin
          for (int i = 0; i < mdd; i++) push(cls, S_MDW, 0, 0, irq_v, -1, -1, 0);
          push(cls, S_MDW, B_HILO, 0, irq_v, -1, -1, 1);
          retire_at(cls, irq_v);
        end
      end
      C_TRAP: begin
        push(cls, S_EXEC, 0, 0, irq_v);
        push(cls, S_EXC, B_EXC | B_PC, 3'd1, irq_v);
      end
      default: begin
        case (cls)
          C_BR, C_J: mstb = B_PC;
          C_ERET:    mstb = B_PC | B_ERET;
          C_JAL:     mstb = B_PC | B_RF;
          C_MFC0:    mstb = B_RF;
          C_MTC0:    mstb = B_CP0;
          C_HILO:    mstb = B_HILO;
          default:   mstb = 12'h0;
        endcase
        push(cls, S_EXEC, mstb, 0, irq_v);
        retire_at(cls, irq_v);
      end
    endcase
  endfunction

  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(posedge clk);
      inst_class = s.cls; imem_ready = s.im; dmem_ready = s.dm; md_done = s.md;
      cond_true = s.cnd; irq = s.irq;
      #1;
      chk("state", 32'(state), 32'(s.st));
      chk("strobes", 32'(strobes), 32'(s.stb));
      chk("exc_cause", 32'(exc_cause), 32'(s.cause));
      chk("retired", retired, 32'(s.ret));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(S_PAUSE));
    chk("rst_strobes", 32'(strobes), 32'h0);
    chk("rst_cause", 32'(exc_cause), 32'h0);
    chk("rst_retired", retired, 32'h0);
    @(posedge clk);
    imem_ready = 0; dmem_ready = 0; md_done = 0; cond_true = 0; irq = 0;
    #1;
    chk("pause_state", 32'(state), 32'(S_PAUSE));
    chk("pause_strobes", 32'(strobes), 32'h0);
    reset_n = 1'b1;
    exp_ret = 0;
    q.delete();
  endtask

  function automatic int rdelay(input int t);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return t;
    if (r == 1) return t - 1;
    return $urandom_range(0, 4);
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    build(C_ALUR, 0, 0, 0, 0, 0);
    build(C_LOAD, 0, 0, 3, 0, 0);
    build(C_STORE, 0, 1, MEM_T, 0, 0);
    build(C_TRAPC, 0, 0, 0, 0, 0);
    build(C_TRAPC, 1, 2, 0, 0, 0);
    build(C_MD, 0, 0, 0, 9, 0);
    build(C_MD, 0, 0, 0, MD_T, 0);
    build(C_MD, 0, 0, 0, MD_T - 1, 0);
    build(C_NOP, 0, MEM_T - 1, 0, 0, 0);
    build(C_NOP, 0, MEM_T, 0, 0, 0);
    build(C_STORE, 0, 0, MEM_T - 1, 0, 0);
    build(C_LOAD, 0, 0, MEM_T, 0, 0);
    build(C_BR, 1, 0, 0, 0, 0);
    build(C_BR, 0, 0, 0, 0, 0);
    build(C_J, 0, 0, 0, 0, 0);
    build(C_JAL, 0, 0, 0, 0, 0);
    build(C_ERET, 0, 0, 0, 0, 0);
    build(C_TRAP, 0, 0, 0, 0, 0);
    build(C_MFC0, 0, 0, 0, 0, 0);
    build(C_MTC0, 0, 0, 0, 0, 0);
    build(C_HILO, 0, 0, 0, 0, 0);
    build(C_RSVD, 0, 0, 0, 0, 0);
    build(C_ALUI, 0, 0, 0, 0, 1);
    build(C_ALUR, 0, 0, 0, 0, 0);
    run_steps(q.size());

    // Abort a load while it is waiting in MEM.
    build(C_LOAD, 0, 0, 10, 0, 0);
    run_steps(5);
    chk("mid_mem_state", 32'(state), 32'(S_MEM));
    do_reset();

    for (int n = 0; n < 40; n++) begin
      build(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rdelay(MEM_T),
            rdelay(MEM_T), rdelay(MD_T), 1'($urandom_range(0, 1)));
      run_steps(q.size());
    end

    @(posedge clk);
    #1;
    chk("final_state", 32'(state), 32'(S_FETCH));
    chk("final_retired", retired, 32'(exp_ret));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
